// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Builds 32-bit MIPS-I instruction words from a mnemonic code plus operand
//   fields. Each word gets a sequential imem word address. Word and address
//   are streamed to the imem write port through one output register stage
//   with a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge); asynchronous active-low reset
//   clear             synchronous re-init. It flushes the output stage, resets
//                     the address, and clears the flags and the count.
//   in_valid/in_ready operand-set handshake
//   in_mnem           mnemonic code (0..30 legal, 31 illegal)
//   in_rs/rt/rd/shamt register and shift fields
//   in_imm            16-bit immediate or branch offset
//   in_target         26-bit jump target
//   out_valid/ready   imem write handshake
//   out_instr/addr    encoded word and its word address
//   count             words transferred out, saturating
//   err_illegal       sticky: an illegal mnemonic was consumed
//   wrapped           sticky: the address counter wrapped back to BASE_ADDR
module mips_instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W:0]   count,
   output logic              err_illegal,
   output logic              wrapped
);

   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] MAX_ADDR = '1;
   localparam logic [ADDR_W:0]   MAX_CNT  = '1;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t              state_q, state_d;
   logic [31:0]         out_instr_q, out_instr_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                err_illegal_q, err_illegal_d;
   logic                wrapped_q, wrapped_d;

   // ---------------- encoder ----------------
   logic [5:0]  op, funct;
   logic [4:0]  rs_f, rt_f, rd_f, shamt_f;
   logic        is_i, is_j, legal;
   logic [31:0] word;

   always_comb begin
      op      = 6'h00;
      funct   = 6'h00;
      rs_f    = in_rs;
      rt_f    = in_rt;
      rd_f    = in_rd;
      shamt_f = 5'd0;
      is_i    = 1'b0;
      is_j    = 1'b0;
      legal   = 1'b1;
      case (in_mnem)
         5'd0:  funct = 6'h20;
         5'd1:  funct = 6'h21;
         5'd2:  funct = 6'h22;
         5'd3:  funct = 6'h23;
         5'd4:  funct = 6'h24;
         5'd5:  funct = 6'h25;
         5'd6:  funct = 6'h26;
         5'd7:  funct = 6'h27;
         5'd8:  funct = 6'h2A;
         5'd9:  funct = 6'h2B;
         // Constant shifts carry shamt and have no rs operand.
         5'd10: begin funct = 6'h00; shamt_f = in_shamt; rs_f = 5'd0; end
         5'd11: begin funct = 6'h02; shamt_f = in_shamt; rs_f = 5'd0; end
         5'd12: begin funct = 6'h03; shamt_f = in_shamt; rs_f = 5'd0; end
         5'd13: funct = 6'h04;
         5'd14: funct = 6'h06;
         5'd15: funct = 6'h07;
         5'd16: begin funct = 6'h08; rt_f = 5'd0; rd_f = 5'd0; end
         5'd17: begin op = 6'h23; is_i = 1'b1; end
         5'd18: begin op = 6'h2B; is_i = 1'b1; end
         5'd19: begin op = 6'h04; is_i = 1'b1; end
         5'd20: begin op = 6'h05; is_i = 1'b1; end
         5'd21: begin op = 6'h08; is_i = 1'b1; end
         5'd22: begin op = 6'h09; is_i = 1'b1; end
         5'd23: begin op = 6'h0C; is_i = 1'b1; end
         5'd24: begin op = 6'h0D; is_i = 1'b1; end
         5'd25: begin op = 6'h0E; is_i = 1'b1; end
         5'd26: begin op = 6'h0A; is_i = 1'b1; end
         5'd27: begin op = 6'h0B; is_i = 1'b1; end
         5'd28: begin op = 6'h02; is_j = 1'b1; end
         5'd29: begin op = 6'h03; is_j = 1'b1; end
         5'd30: begin op = 6'h0F; is_i = 1'b1; rs_f = 5'd0; end
         default: legal = 1'b0;
      endcase

      if (is_j)
         word = {op, in_target};
      else if (is_i)
         word = {op, rs_f, rt_f, in_imm};
      else
         word = {6'h00, rs_f, rt_f, rd_f, shamt_f, funct};
   end

   // ---------------- handshake / state ----------------
   logic accept, xfer, legal_acc, illegal_acc;

   assign in_ready    = !clear && (state_q == EMPTY || out_ready);
   assign accept      = in_valid && in_ready;
   assign xfer        = (state_q == FULL) && out_ready;
   assign legal_acc   = accept && legal;
   assign illegal_acc = accept && !legal;

   always_comb begin
      state_d       = state_q;
      out_instr_d   = out_instr_q;
      out_addr_d    = out_addr_q;
      next_addr_d   = next_addr_q;
      count_d       = count_q;
      err_illegal_d = err_illegal_q || illegal_acc;
      wrapped_d     = wrapped_q;

      if (xfer && count_q != MAX_CNT)
         count_d = count_q + 1'b1;

      // A legal accept refills the stage even if it is draining this cycle.
      // An illegal accept emits nothing, so a draining stage empties.
      if (legal_acc) begin
         state_d     = FULL;
         out_instr_d = word;
         out_addr_d  = next_addr_q;
         if (next_addr_q == MAX_ADDR) begin
            next_addr_d = BASE;
            wrapped_d   = 1'b1;
         end else begin
            next_addr_d = next_addr_q + 1'b1;
         end
      end else if (xfer) begin
         state_d = EMPTY;
      end

      // clear wins over everything. A pending word is dropped untransferred.
      if (clear) begin
         state_d       = EMPTY;
         out_addr_d    = BASE;
         next_addr_d   = BASE;
         count_d       = '0;
         err_illegal_d = 1'b0;
         wrapped_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= EMPTY;
         out_instr_q   <= '0;
         out_addr_q    <= BASE;
         next_addr_q   <= BASE;
         count_q       <= '0;
         err_illegal_q <= 1'b0;
         wrapped_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_instr_q   <= out_instr_d;
         out_addr_q    <= out_addr_d;
         next_addr_q   <= next_addr_d;
         count_q       <= count_d;
         err_illegal_q <= err_illegal_d;
         wrapped_q     <= wrapped_d;
      end
   end

   assign out_valid   = (state_q == FULL);
   assign out_instr   = out_instr_q;
   assign out_addr    = out_addr_q;
   assign count       = count_q;
   assign err_illegal = err_illegal_q;
   assign wrapped     = wrapped_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
module tb_mips_instr_encoder;

   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
   logic [15:0]   in_imm = '0;
   logic [25:0]   in_target = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic [AW:0]   count;
   logic          err_illegal, wrapped;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .count(count),
      .err_illegal(err_illegal), .wrapped(wrapped)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tgt);
      in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
      in_shamt = sh; in_imm = imm; in_target = tgt;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #2;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 00000000", out_instr); end
      checks++; if (out_addr !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", out_addr); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (err_illegal !== 1'b0 || wrapped !== 1'b0) begin errors++; $display("FAIL reset_flags: got err=%b wrap=%b want 0 0", err_illegal, wrapped); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      tick();
      idle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
      checks++; if (out_instr !== 32'h00221820) begin errors++; $display("FAIL add_instr: got %h want 00221820", out_instr); end
      checks++; if (out_addr !== 2'd0) begin errors++; $display("FAIL add_addr: got %0d want 0", out_addr); end
      $display("add: instr=%h addr=%0d", out_instr, out_addr);
      tick();
      checks++; if (count !== 3'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL add_count: got count=%0d valid=%b want 1 0", count, out_valid); end
   endtask

   task automatic test_back_to_back();
      do_clear();
      out_ready = 1'b1;
      drive(5'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
      tick();
      checks++; if (out_instr !== 32'h8FA80004 || out_addr !== 2'd0) begin errors++; $display("FAIL b2b_lw: got %h@%0d want 8fa80004@0", out_instr, out_addr); end
      $display("b2b: instr=%h addr=%0d", out_instr, out_addr);
      drive(5'd10, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0);
      tick();
      checks++; if (out_instr !== 32'h00031100 || out_addr !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_sll: got %h@%0d v=%b want 00031100@1", out_instr, out_addr, out_valid); end
      $display("b2b: instr=%h addr=%0d", out_instr, out_addr);
      drive(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
      tick();
      checks++; if (out_instr !== 32'h08100000 || out_addr !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_j: got %h@%0d v=%b want 08100000@2", out_instr, out_addr, out_valid); end
      $display("b2b: instr=%h addr=%0d", out_instr, out_addr);
      idle();
      tick();
      checks++; if (out_valid !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL b2b_count: got v=%b count=%0d want 0 3", out_valid, count); end
   endtask

   task automatic test_hold();
      do_clear();
      out_ready = 1'b0;
      drive(5'd6, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
      tick();
      drive(5'd5, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
      for (int k = 0; k < 3; k++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: cycle %0d got %b want 0", k, in_ready); end
         checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00853026 || out_addr !== 2'd0) begin errors++; $display("FAIL hold_stable: cycle %0d got v=%b %h@%0d want 1 00853026@0", k, out_valid, out_instr, out_addr); end
         $display("hold: cycle %0d instr=%h addr=%0d in_ready=%b", k, out_instr, out_addr, in_ready);
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
      tick();
      idle();
      checks++; if (out_instr !== 32'h00210825 || out_addr !== 2'd1 || count !== 3'd1) begin errors++; $display("FAIL hold_next: got %h@%0d count=%0d want 00210825@1 1", out_instr, out_addr, count); end
      $display("hold: next instr=%h addr=%0d count=%0d", out_instr, out_addr, count);
      tick();
      checks++; if (count !== 3'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got count=%0d v=%b want 2 0", count, out_valid); end
   endtask

   task automatic test_illegal();
      do_clear();
      out_ready = 1'b1;
      drive(5'd31, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1111, 26'h0);
      tick();
      checks++; if (out_valid !== 1'b0 || err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got v=%b err=%b want 0 1", out_valid, err_illegal); end
      $display("illegal: out_valid=%b err=%b", out_valid, err_illegal);
      drive(5'd21, 5'd0, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'h0);
      tick();
      checks++; if (out_instr !== 32'h2001FFFF || out_addr !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal_addi: got %h@%0d v=%b want 2001ffff@0", out_instr, out_addr, out_valid); end
      $display("illegal: addi instr=%h addr=%0d", out_instr, out_addr);
      drive(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      tick();
      checks++; if (out_valid !== 1'b0 || count !== 3'd1 || err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_drain: got v=%b count=%0d err=%b want 0 1 1", out_valid, count, err_illegal); end
      drive(5'd16, 5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      tick();
      checks++; if (out_instr !== 32'h03E00008 || out_addr !== 2'd1) begin errors++; $display("FAIL jr_forced: got %h@%0d want 03e00008@1", out_instr, out_addr); end
      $display("jr: instr=%h addr=%0d", out_instr, out_addr);
      drive(5'd30, 5'd5, 5'd7, 5'd0, 5'd0, 16'h1234, 26'h0);
      tick();
      checks++; if (out_instr !== 32'h3C071234 || out_addr !== 2'd2) begin errors++; $display("FAIL lui_forced: got %h@%0d want 3c071234@2", out_instr, out_addr); end
      $display("lui: instr=%h addr=%0d", out_instr, out_addr);
      idle();
      tick();
   endtask

   task automatic test_wrap_clear();
      logic [31:0] exp_w;
      logic [1:0]  exp_a;
      do_clear();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(5'd24, 5'd2, 5'd3, 5'd0, 5'd0, 16'(i), 26'h0);
         tick();
         exp_w = 32'h34430000 + 32'(i);
         exp_a = 2'(i);
         checks++; if (out_instr !== exp_w || out_addr !== exp_a) begin errors++; $display("FAIL wrap_word%0d: got %h@%0d want %h@%0d", i, out_instr, out_addr, exp_w, exp_a); end
         $display("wrap: ori %0d instr=%h addr=%0d wrapped=%b", i, out_instr, out_addr, wrapped);
         if (i == 2) begin
            checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL wrap_early: got %b want 0", wrapped); end
         end
      end
      checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_flag: got %b want 1", wrapped); end
      for (int i = 0; i < 4; i++) begin
         drive(5'd24, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0, 26'h0);
         tick();
      end
      idle();
      tick();
      checks++; if (count !== 3'd7) begin errors++; $display("FAIL count_sat: got %0d want 7", count); end
      $display("count: after 9 transfers count=%0d", count);
      drive(5'd24, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0, 26'h0);
      tick();
      clear = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %b want 0", in_ready); end
      tick();
      clear = 1'b0;
      idle();
      checks++; if (out_valid !== 1'b0 || out_addr !== 2'd0 || count !== 3'd0) begin errors++; $display("FAIL clear_state: got v=%b addr=%0d count=%0d want 0 0 0", out_valid, out_addr, count); end
      checks++; if (wrapped !== 1'b0 || err_illegal !== 1'b0) begin errors++; $display("FAIL clear_flags: got wrap=%b err=%b want 0 0", wrapped, err_illegal); end
      $display("clear: v=%b addr=%0d count=%0d wrapped=%b", out_valid, out_addr, count, wrapped);
      tick();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL clear_discard: got count=%0d want 0", count); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
      tick();
      idle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got v=%b want 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 2'd0) begin errors++; $display("FAIL areset_out: got v=%b %h@%0d want 0 00000000@0", out_valid, out_instr, out_addr); end
      checks++; if (count !== 3'd0 || wrapped !== 1'b0 || err_illegal !== 1'b0) begin errors++; $display("FAIL areset_misc: got count=%0d wrap=%b err=%b want 0 0 0", count, wrapped, err_illegal); end
      $display("async reset: v=%b instr=%h count=%0d", out_valid, out_instr, count);
      out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_after: got count=%0d v=%b want 0 0", count, out_valid); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_hold();
      test_illegal();
      test_wrap_clear();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish within 50000 time units");
      $fatal(1, "timeout");
   end

endmodule
